// File: rtl/uart_receiver_pkg.sv
// ============================================================================
// Module : uart_receiver_pkg
// Brief  : Controller state encodings and seven-segment code table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_receiver_pkg;

  localparam int Num_state_bits = 2;

  typedef enum logic [Num_state_bits-1:0] {
    IDLE      = 2'd0,
    STARTING  = 2'd1,
    RECEIVING = 2'd2
  } state_e;

  // {dp,g,f,e,d,c,b,a}, active-low, decimal point permanently off
  localparam logic [7:0] SEG7_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg7_encode(input logic [3:0] hex);
    return SEG7_TABLE[hex];
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_receiver_hex_to_7seg.sv
// ============================================================================
// Module : hex_to_7seg
// Brief  : One hex digit to an active-low seven-segment code.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_to_7seg
  import uart_receiver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg7_encode(hex_i);

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module : uart_receiver
// Brief  : 8N1 UART receiver, 8x oversampled, with seven-segment debug taps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int word_size        = 8,
  parameter int half_word        = 4,
  parameter int Num_counter_bits = 4
) (
  input  logic                 Sample_clk,
  input  logic                 rst_b,
  input  logic                 Serial_in,
  input  logic                 read_not_ready_in,
  output logic [word_size-1:0] RCV_datareg,
  output logic                 read_not_ready_out,
  output logic                 Error1,
  output logic                 Error2,
  output logic [7:0]           RCV_datareg_least,
  output logic [7:0]           RCV_datareg_most,
  output logic [7:0]           RCV_shftreg_least,
  output logic [7:0]           RCV_shftreg_most,
  output logic [7:0]           Sample_counter_display,
  output logic [7:0]           Bit_counter_display,
  output logic                 clr_Sample_counter,
  output logic                 inc_Sample_counter,
  output logic                 clr_Bit_counter,
  output logic                 inc_Bit_counter,
  output logic                 shift,
  output logic                 load
);

  localparam logic [Num_counter_bits-1:0] c_sc_start = Num_counter_bits'(3);
  localparam logic [Num_counter_bits-1:0] c_sc_last  = Num_counter_bits'(7);
  localparam logic [Num_counter_bits:0]   c_bits     = (Num_counter_bits+1)'(word_size);

  state_e                      state_q, state_d;
  logic [Num_counter_bits-1:0] Sample_counter_q;
  logic [Num_counter_bits:0]   Bit_counter_q;
  logic [word_size-1:0]        RCV_shftreg_q;
  logic [word_size-1:0]        RCV_datareg_q;

  // ---------------- controller ----------------
  always_ff @(posedge Sample_clk) begin
    if (rst_b) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    clr_Sample_counter = 1'b0;
    inc_Sample_counter = 1'b0;
    clr_Bit_counter    = 1'b0;
    inc_Bit_counter    = 1'b0;
    shift              = 1'b0;
    load               = 1'b0;
    read_not_ready_out = 1'b0;
    Error1             = 1'b0;
    Error2             = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Serial_in) state_d = STARTING;
      end
      STARTING: begin
        // A high sample before mid-start-bit is treated as a glitch
        if (Serial_in) begin
          clr_Sample_counter = 1'b1;
          state_d            = IDLE;
        end else if (Sample_counter_q == c_sc_start) begin
          clr_Sample_counter = 1'b1;
          state_d            = RECEIVING;
        end else begin
          inc_Sample_counter = 1'b1;
        end
      end
      RECEIVING: begin
        if (Sample_counter_q < c_sc_last) begin
          inc_Sample_counter = 1'b1;
        end else begin
          clr_Sample_counter = 1'b1;
          if (Bit_counter_q != c_bits) begin
            shift           = 1'b1;
            inc_Bit_counter = 1'b1;
          end else begin
            read_not_ready_out = 1'b1;
            clr_Bit_counter    = 1'b1;
            state_d            = IDLE;
            if (read_not_ready_in) Error1 = 1'b1;
            else if (!Serial_in)   Error2 = 1'b1;
            else                   load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge Sample_clk) begin
    if (rst_b) begin
      Sample_counter_q <= '0;
      Bit_counter_q    <= '0;
      RCV_shftreg_q    <= '0;
      RCV_datareg_q    <= '0;
    end else begin
      if (clr_Sample_counter)      Sample_counter_q <= '0;
      else if (inc_Sample_counter) Sample_counter_q <= Sample_counter_q + 1'b1;
      if (clr_Bit_counter)         Bit_counter_q    <= '0;
      else if (inc_Bit_counter)    Bit_counter_q    <= Bit_counter_q + 1'b1;
      if (shift) RCV_shftreg_q <= {Serial_in, RCV_shftreg_q[word_size-1:1]};
      if (load)  RCV_datareg_q <= RCV_shftreg_q;
    end
  end

  assign RCV_datareg = RCV_datareg_q;

  // ---------------- debug displays ----------------
  hex_to_7seg u_seg_data_lo (.hex_i(RCV_datareg_q[half_word-1:0]),         .seg_o(RCV_datareg_least));
  hex_to_7seg u_seg_data_hi (.hex_i(RCV_datareg_q[word_size-1:half_word]), .seg_o(RCV_datareg_most));
  hex_to_7seg u_seg_shft_lo (.hex_i(RCV_shftreg_q[half_word-1:0]),         .seg_o(RCV_shftreg_least));
  hex_to_7seg u_seg_shft_hi (.hex_i(RCV_shftreg_q[word_size-1:half_word]), .seg_o(RCV_shftreg_most));
  hex_to_7seg u_seg_samp    (.hex_i(Sample_counter_q),                     .seg_o(Sample_counter_display));
  hex_to_7seg u_seg_bit     (.hex_i(Bit_counter_q[Num_counter_bits-1:0]),  .seg_o(Bit_counter_display));

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module : tb_uart_receiver
// Brief  : Self-checking bench for uart_receiver against a frame-timing model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       ser = 1'b1;
  logic       rnr_in = 1'b0;

  logic [7:0] datareg, d_lo, d_hi, s_lo, s_hi, sc_disp, bc_disp;
  logic       rnr_out, err1, err2, clr_s, inc_s, clr_b, inc_b, shift, load;

  int checks = 0;
  int failures = 0;
  int n_load = 0, n_e1 = 0, n_e2 = 0;

  always #5 clk = ~clk;

  uart_receiver dut (
    .Sample_clk(clk), .rst_b(rst_b), .Serial_in(ser), .read_not_ready_in(rnr_in),
    .RCV_datareg(datareg), .read_not_ready_out(rnr_out), .Error1(err1), .Error2(err2),
    .RCV_datareg_least(d_lo), .RCV_datareg_most(d_hi),
    .RCV_shftreg_least(s_lo), .RCV_shftreg_most(s_hi),
    .Sample_counter_display(sc_disp), .Bit_counter_display(bc_disp),
    .clr_Sample_counter(clr_s), .inc_Sample_counter(inc_s),
    .clr_Bit_counter(clr_b), .inc_Bit_counter(inc_b),
    .shift(shift), .load(load)
  );

  function automatic logic [7:0] seg(input logic [3:0] v);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[v];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is tracked by the cycle index of its first low sample.
  bit         m_busy = 1'b0;
  int         m_t0 = 0;
  int         n = 0;
  logic [7:0] m_shft = 8'h00;
  logic [7:0] m_data = 8'h00;

  always @(negedge clk) begin : cmp
    logic e_clrs, e_incs, e_clrb, e_incb, e_shift, e_load, e_rnr, e_e1, e_e2;
    int   e_sc, e_bc, off, rel, k;
    n++;
    if (rst_b) begin
      m_busy = 1'b0;
      m_shft = 8'h00;
      m_data = 8'h00;
    end else begin
      {e_clrs, e_incs, e_clrb, e_incb, e_shift, e_load, e_rnr, e_e1, e_e2} = '0;
      e_sc = 0;
      e_bc = 0;
      if (m_busy) begin
        off = n - m_t0;
        if (off <= 4) begin
          e_sc = off - 1;
          if (ser)            begin e_clrs = 1; m_busy = 1'b0; end
          else if (off == 4)  e_clrs = 1;
          else                e_incs = 1;
        end else begin
          rel  = off - 4;
          e_sc = (rel - 1) % 8;
          e_bc = (rel - 1) / 8;
          if (rel % 8 != 0) e_incs = 1;
          else begin
            e_clrs = 1;
            k = rel / 8;
            if (k <= 8) begin
              e_shift = 1;
              e_incb  = 1;
            end else begin
              e_rnr  = 1;
              e_clrb = 1;
              m_busy = 1'b0;
              if (rnr_in)   e_e1 = 1;
              else if (!ser) e_e2 = 1;
              else          e_load = 1;
            end
          end
        end
      end
      chk("clr_Sample_counter", {7'd0, clr_s},   {7'd0, e_clrs});
      chk("inc_Sample_counter", {7'd0, inc_s},   {7'd0, e_incs});
      chk("clr_Bit_counter",    {7'd0, clr_b},   {7'd0, e_clrb});
      chk("inc_Bit_counter",    {7'd0, inc_b},   {7'd0, e_incb});
      chk("shift",              {7'd0, shift},   {7'd0, e_shift});
      chk("load",               {7'd0, load},    {7'd0, e_load});
      chk("read_not_ready_out", {7'd0, rnr_out}, {7'd0, e_rnr});
      chk("Error1",             {7'd0, err1},    {7'd0, e_e1});
      chk("Error2",             {7'd0, err2},    {7'd0, e_e2});
      chk("RCV_datareg",        datareg, m_data);
      chk("RCV_datareg_least",  d_lo, seg(m_data[3:0]));
      chk("RCV_datareg_most",   d_hi, seg(m_data[7:4]));
      chk("RCV_shftreg_least",  s_lo, seg(m_shft[3:0]));
      chk("RCV_shftreg_most",   s_hi, seg(m_shft[7:4]));
      chk("Sample_counter_display", sc_disp, seg(4'(e_sc)));
      chk("Bit_counter_display",    bc_disp, seg(4'(e_bc)));
      if (e_shift) m_shft = {ser, m_shft[7:1]};
      if (e_load)  m_data = m_shft;
      if (!m_busy && !ser && !(e_rnr || e_clrs)) begin
        m_busy = 1'b1;
        m_t0   = n;
      end
      if (load) n_load++;
      if (err1) n_e1++;
      if (err2) n_e2++;
    end
  end

  task automatic drive_line(input logic v, input int cycles);
    repeat (cycles) begin
      ser = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic rnr);
    rnr_in = rnr;
    drive_line(1'b0, 8);
    for (int i = 0; i < 8; i++) drive_line(b[i], 8);
    drive_line(stop, 8);
  endtask

  initial begin
    int       l0, e10, e20;
    logic [7:0] rb;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("reset_datareg_least", d_lo, 8'hC0);
    chk("reset_datareg_most",  d_hi, 8'hC0);
    chk("reset_shftreg_least", s_lo, 8'hC0);
    chk("reset_sample_disp",   sc_disp, 8'hC0);
    chk("reset_bit_disp",      bc_disp, 8'hC0);
    chk("reset_strobes", {2'b0, clr_s, inc_s, clr_b, inc_b, shift, load}, 8'h00);
    drive_line(1'b1, 10);

    // bits 1,0,1,0,1,1,0,1 LSB first
    l0 = n_load;
    send_frame(8'hB5, 1'b1, 1'b0);
    drive_line(1'b1, 8);
    chk("b5_load_count", 8'(n_load - l0), 8'd1);
    chk("b5_datareg", datareg, 8'hB5);
    chk("b5_least", d_lo, 8'h92);
    chk("b5_most",  d_hi, 8'h83);
    chk("b5_model", m_data, 8'hB5);

    e10 = n_e1;
    send_frame(8'h37, 1'b1, 1'b1);
    drive_line(1'b1, 8);
    rnr_in = 1'b0;
    chk("overrun_err1_count", 8'(n_e1 - e10), 8'd1);
    chk("overrun_datareg", datareg, 8'hB5);
    chk("overrun_shftreg_lo", s_lo, 8'hF8);

    e20 = n_e2;
    send_frame(8'h8F, 1'b1, 1'b0);
    drive_line(1'b1, 8);
    chk("8f_datareg", datareg, 8'h8F);
    chk("8f_least", d_lo, 8'h8E);
    chk("8f_most",  d_hi, 8'h80);
    drive_line(1'b0, 80);
    drive_line(1'b1, 16);
    chk("framing_err2_count", 8'(n_e2 - e20), 8'd1);
    chk("framing_datareg", datareg, 8'h8F);
    chk("framing_shftreg_hi", s_hi, 8'hC0);

    drive_line(1'b0, 3);
    drive_line(1'b1, 8);
    chk("glitch_sample_disp", sc_disp, 8'hC0);
    chk("glitch_bit_disp",    bc_disp, 8'hC0);
    chk("glitch_datareg",     datareg, 8'h8F);

    drive_line(1'b0, 8);
    drive_line(1'b1, 8);
    drive_line(1'b0, 8);
    drive_line(1'b1, 5);
    rst_b = 1'b1;
    drive_line(1'b1, 5);
    rst_b = 1'b0;
    chk("midreset_datareg", datareg, 8'h00);
    chk("midreset_shft_lo", s_lo, 8'hC0);
    chk("midreset_sample",  sc_disp, 8'hC0);
    chk("midreset_bit",     bc_disp, 8'hC0);
    chk("midreset_strobes", {2'b0, clr_s, inc_s, clr_b, inc_b, shift, load}, 8'h00);
    drive_line(1'b1, 10);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          rb = 8'($urandom);
          send_frame(rb, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
        end
        2: drive_line(1'b0, $urandom_range(1, 5));
        default: begin
          for (int j = 0; j < 60; j++) drive_line(1'($urandom_range(0, 1)), 1);
        end
      endcase
      rnr_in = 1'($urandom_range(0, 1));
      drive_line(1'b1, $urandom_range(0, 12));
    end
    rnr_in = 1'b0;
    drive_line(1'b1, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
